// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronised line, mid-bit sampling, one-cycle byte strobe.
// Detects false starts, flags a low stop bit once, then waits for the line to recover.
module uart_rx #(
  parameter  int CLKS_PER_BIT = 104,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t           state, state_nx;
  logic [1:0]       sync;
  logic             din_s;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [7:0]       shift, shift_nx, data_nx;
  logic             valid_nx, ferr_nx;

  assign din_s = sync[1];
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shift     <= '0;
      data_out  <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], din};
      state     <= state_nx;
      cnt       <= cnt_nx;
      idx       <= idx_nx;
      shift     <= shift_nx;
      data_out  <= data_nx;
      valid     <= valid_nx;
      frame_err <= ferr_nx;
    end
  end

  // START samples half a bit in, so every later full-bit step lands mid-bit;
  // STOP exits at stop-bit midpoint to leave half a bit to catch the next start.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    idx_nx   = idx;
    shift_nx = shift;
    data_nx  = data_out;
    valid_nx = 1'b0;
    ferr_nx  = 1'b0;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (!din_s) state_nx = START;
      end
      START: if (cnt == HALF) begin
        cnt_nx   = '0;
        idx_nx   = '0;
        state_nx = din_s ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_nx   = '0;
        shift_nx = {din_s, shift[7:1]};
        idx_nx   = idx + 1'b1;
        if (idx == 3'd7) state_nx = STOP;
      end
      STOP: if (cnt == LAST) begin
        cnt_nx = '0;
        if (din_s) begin
          data_nx  = shift;
          valid_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          ferr_nx  = 1'b1;
          state_nx = WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cnt_nx = '0;
        if (din_s) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frames at nominal/skewed baud plus hand-built
// false-start, stuck-low and mid-frame-reset sequences, checked via a byte scoreboard.
module tb_uart_rx;
  localparam int CPB = 104;

  logic       tb_clk = 1'b0;
  logic       rst, din;
  logic [7:0] data_out;
  logic       valid, frame_err, busy;

  int n_checks   = 0;
  int n_fail     = 0;
  int ferr_seen  = 0;
  int valid_seen = 0;
  logic [7:0] exp_q[$];

  always #5 tb_clk = ~tb_clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(tb_clk), .rst(rst), .din(din),
    .data_out(data_out), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: every valid pops one expected byte
  always @(negedge tb_clk) begin
    if (!rst) begin
      if (valid && frame_err) begin
        n_checks++; n_fail++;
        $display("FAIL strobe_exclusive: valid and frame_err both high");
      end
      if (valid) begin
        valid_seen++;
        if (exp_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL spurious_valid: got byte %0h expected no strobe", data_out);
        end else
          check("rx_byte", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
      end
      if (frame_err) ferr_seen++;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int per, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      din = fr[i];
      repeat (per) @(negedge tb_clk);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < 5000) begin
      @(negedge tb_clk);
      t++;
    end
    check({name, "_drain"}, {31'h0, t < 5000}, 32'h1);
  endtask

  typedef struct {
    logic [7:0] data;
    int         per;
    int         gap;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int f0, v0;
    logic [9:0] fr;
    // gap 0 = next frame's start bit follows the stop bit immediately
    vecs[0]  = '{8'h55, 104, 150, 8'h55};
    vecs[1]  = '{8'h00, 104, 0,   8'h00};
    vecs[2]  = '{8'hFF, 104, 0,   8'hFF};
    vecs[3]  = '{8'hFE, 104, 0,   8'hFE};
    vecs[4]  = '{8'h0E, 104, 150, 8'h0E};
    vecs[5]  = '{8'h00, 101, 150, 8'h00};
    vecs[6]  = '{8'hFF, 101, 150, 8'hFF};
    vecs[7]  = '{8'h53, 101, 150, 8'h53};
    vecs[8]  = '{8'h00, 107, 150, 8'h00};
    vecs[9]  = '{8'hFF, 107, 150, 8'hFF};
    vecs[10] = '{8'h53, 107, 150, 8'h53};

    din = 1'b1;
    rst = 1'b1;
    repeat (5) @(negedge tb_clk);
    rst = 1'b0;
    @(negedge tb_clk);
    check("rst_data_out",  {24'h0, data_out}, 32'h0);
    check("rst_valid",     {31'h0, valid},     32'h0);
    check("rst_frame_err", {31'h0, frame_err}, 32'h0);
    check("rst_busy",      {31'h0, busy},      32'h0);

    for (int i = 0; i < 11; i++) begin
      exp_q.push_back(vecs[i].exp);
      send_byte(vecs[i].data, vecs[i].per, 1'b1);
      if (vecs[i].gap > 0) begin
        check("idle_at_stop_end", {31'h0, busy}, 32'h0);
        repeat (vecs[i].gap) @(negedge tb_clk);
      end
    end
    drain("table");
    check("table_valid_count", valid_seen, 11);
    check("table_no_ferr", ferr_seen, 0);

    // false start: 30-cycle glitch is gone before the start-bit midpoint
    v0 = valid_seen;
    din = 1'b0;
    repeat (10) @(negedge tb_clk);
    check("glitch_busy", {31'h0, busy}, 32'h1);
    repeat (20) @(negedge tb_clk);
    din = 1'b1;
    repeat (60) @(negedge tb_clk);
    check("glitch_idle", {31'h0, busy}, 32'h0);
    check("glitch_no_valid", valid_seen, v0);
    check("glitch_no_ferr", ferr_seen, 0);
    exp_q.push_back(8'hA5);
    send_byte(8'hA5, CPB, 1'b1);
    drain("after_glitch");
    check("after_glitch_data", {24'h0, data_out}, 32'hA5);

    // framing error followed by a line stuck low
    f0 = ferr_seen;
    v0 = valid_seen;
    send_byte(8'h3C, CPB, 1'b0);
    repeat (3 * 10 * CPB) @(negedge tb_clk);
    check("stuck_busy", {31'h0, busy}, 32'h1);
    check("stuck_one_ferr", ferr_seen - f0, 1);
    check("stuck_no_valid", valid_seen, v0);
    check("stuck_data_kept", {24'h0, data_out}, 32'hA5);
    din = 1'b1;
    repeat (20) @(negedge tb_clk);
    check("stuck_recover_idle", {31'h0, busy}, 32'h0);
    exp_q.push_back(8'h10);
    send_byte(8'h10, CPB, 1'b1);
    drain("after_ferr");
    check("after_ferr_data", {24'h0, data_out}, 32'h10);
    check("after_ferr_count", ferr_seen - f0, 1);

    // reset inside bit 4 of 0xC3; the sender shares the reset so the line goes idle
    v0 = valid_seen;
    fr = {1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      din = fr[i];
      repeat ((i == 4) ? 50 : CPB) @(negedge tb_clk);
    end
    rst = 1'b1;
    din = 1'b1;
    @(negedge tb_clk);
    rst = 1'b0;
    @(negedge tb_clk);
    check("midrst_data_out",  {24'h0, data_out}, 32'h0);
    check("midrst_valid",     {31'h0, valid},     32'h0);
    check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
    check("midrst_busy",      {31'h0, busy},      32'h0);
    repeat (600) @(negedge tb_clk);
    check("midrst_no_valid", valid_seen, v0);
    exp_q.push_back(8'h22);
    send_byte(8'h22, CPB, 1'b1);
    drain("after_rst");
    check("after_rst_data", {24'h0, data_out}, 32'h22);
    check("total_valid", valid_seen, 14);
    check("total_ferr", ferr_seen, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    repeat (90000) @(posedge tb_clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

endmodule
